// File: rtl/instruction_decode_if.sv
// instruction_decode_if: IF/ID, EX/MEM, WB and ID/EX signal bundle around the decode stage
//   master : decode side (consumes IF/ID, EX/MEM, WB; drives fetch control and ID/EX)
//   slave  : pipeline side (drives IF/ID, EX/MEM, WB; consumes fetch control and ID/EX)
interface instruction_decode_if;
    logic [31:0] IF_ID_pc, IF_ID_inst;
    logic        EX_MEM_reg_write, EX_MEM_mem_read;
    logic [4:0]  EX_MEM_rd;
    logic [31:0] EX_MEM_alu_result;
    logic        WB_reg_write;
    logic [4:0]  WB_rd;
    logic [31:0] WB_data;
    logic [31:0] pc_branch;
    logic        pc_src, pc_write, IF_ID_write, IF_flush;
    logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [2:0]  ID_EX_funct3;
    logic        ID_EX_funct7b5;
    logic        ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg, ID_EX_alu_src;
    logic [1:0]  ID_EX_alu_op;
    modport master (
        input  IF_ID_pc, IF_ID_inst, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_rd, EX_MEM_alu_result,
               WB_reg_write, WB_rd, WB_data,
        output pc_branch, pc_src, pc_write, IF_ID_write, IF_flush,
               ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
               ID_EX_funct3, ID_EX_funct7b5, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write,
               ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_alu_op
    );
    modport slave (
        output IF_ID_pc, IF_ID_inst, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_rd, EX_MEM_alu_result,
               WB_reg_write, WB_rd, WB_data,
        input  pc_branch, pc_src, pc_write, IF_ID_write, IF_flush,
               ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
               ID_EX_funct3, ID_EX_funct7b5, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write,
               ID_EX_mem_to_reg, ID_EX_alu_src, ID_EX_alu_op
    );
endinterface

// File: rtl/instruction_decode.sv
// instruction_decode: RISC-V decode stage (register file, immediates, control, hazards, branch resolve)
//   clk, reset : clock and synchronous active-high reset
//   bus        : instruction_decode_if.master (IF/ID, EX/MEM, WB in; fetch control, ID/EX out)
//   ID_BNE_EN  : when defined, funct3 001 under the branch opcode decodes as BNE
module instruction_decode (
    input logic clk,
    input logic reset,
    instruction_decode_if.master bus
);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011;
    logic [31:0] rf [32];
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic        is_r, is_i, is_l, is_s, is_beq, is_bne, is_b, use_rs1, use_rs2;
    logic        hz_ex, hz_mem, stall, fwd1, fwd2, equal, taken;
    logic [31:0] rs1_rf, rs2_rf, br1, br2, imm;
    logic [1:0]  alu_op;
    assign inst    = bus.IF_ID_inst;
    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign rs1     = inst[19:15];
    assign rs2     = inst[24:20];
    assign rd      = inst[11:7];
    assign is_r    = opcode == OP_R;
    assign is_i    = opcode == OP_I;
    assign is_l    = opcode == OP_L;
    assign is_s    = opcode == OP_S;
    assign is_beq  = opcode == OP_B && funct3 == 3'b000;
`ifdef ID_BNE_EN
    assign is_bne  = opcode == OP_B && funct3 == 3'b001;
`else
    assign is_bne  = 1'b0;
`endif
    assign is_b    = is_beq | is_bne;
    assign use_rs1 = is_r | is_i | is_l | is_s | is_b;
    assign use_rs2 = is_r | is_s | is_b;
    // x0 never matches, so it can never raise a hazard
    assign hz_ex  = bus.ID_EX_rd != 5'd0 &&
                    ((use_rs1 && rs1 == bus.ID_EX_rd) || (use_rs2 && rs2 == bus.ID_EX_rd));
    assign hz_mem = bus.EX_MEM_rd != 5'd0 &&
                    ((use_rs1 && rs1 == bus.EX_MEM_rd) || (use_rs2 && rs2 == bus.EX_MEM_rd));
    assign stall  = (bus.ID_EX_mem_read && hz_ex) || (is_b && bus.ID_EX_reg_write && hz_ex) ||
                    (is_b && bus.EX_MEM_mem_read && hz_mem);
    // reads see a same-cycle WB write
    assign rs1_rf = rs1 == 5'd0 ? 32'd0 : (bus.WB_reg_write && bus.WB_rd == rs1) ? bus.WB_data : rf[rs1];
    assign rs2_rf = rs2 == 5'd0 ? 32'd0 : (bus.WB_reg_write && bus.WB_rd == rs2) ? bus.WB_data : rf[rs2];
    // branch compare takes a completed ALU result straight from EX/MEM
    assign fwd1  = bus.EX_MEM_reg_write && !bus.EX_MEM_mem_read && bus.EX_MEM_rd != 5'd0 && bus.EX_MEM_rd == rs1;
    assign fwd2  = bus.EX_MEM_reg_write && !bus.EX_MEM_mem_read && bus.EX_MEM_rd != 5'd0 && bus.EX_MEM_rd == rs2;
    assign br1   = fwd1 ? bus.EX_MEM_alu_result : rs1_rf;
    assign br2   = fwd2 ? bus.EX_MEM_alu_result : rs2_rf;
    assign equal = br1 == br2;
    assign taken = is_beq ? equal : is_bne ? !equal : 1'b0;
    assign imm   = (is_i | is_l) ? {{20{inst[31]}}, inst[31:20]} :
                   is_s ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                   is_b ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} : 32'd0;
    assign alu_op = is_r ? 2'b10 : is_i ? 2'b11 : is_b ? 2'b01 : 2'b00;
    assign bus.pc_branch   = bus.IF_ID_pc + {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign bus.pc_src      = taken && !stall;
    assign bus.IF_flush    = bus.pc_src;
    assign bus.pc_write    = !stall;
    assign bus.IF_ID_write = !stall;
    always_ff @(posedge clk) begin
        if (reset)
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        else if (bus.WB_reg_write && bus.WB_rd != 5'd0)
            rf[bus.WB_rd] <= bus.WB_data;
    end
    always_ff @(posedge clk) begin
        if (reset || stall) begin
            bus.ID_EX_pc         <= 32'd0;
            bus.ID_EX_rs1_data   <= 32'd0;
            bus.ID_EX_rs2_data   <= 32'd0;
            bus.ID_EX_imm        <= 32'd0;
            bus.ID_EX_rs1        <= 5'd0;
            bus.ID_EX_rs2        <= 5'd0;
            bus.ID_EX_rd         <= 5'd0;
            bus.ID_EX_funct3     <= 3'd0;
            bus.ID_EX_funct7b5   <= 1'b0;
            bus.ID_EX_reg_write  <= 1'b0;
            bus.ID_EX_mem_read   <= 1'b0;
            bus.ID_EX_mem_write  <= 1'b0;
            bus.ID_EX_mem_to_reg <= 1'b0;
            bus.ID_EX_alu_src    <= 1'b0;
            bus.ID_EX_alu_op     <= 2'b00;
        end else begin
            bus.ID_EX_pc         <= bus.IF_ID_pc;
            bus.ID_EX_rs1_data   <= rs1_rf;
            bus.ID_EX_rs2_data   <= rs2_rf;
            bus.ID_EX_imm        <= imm;
            bus.ID_EX_rs1        <= rs1;
            bus.ID_EX_rs2        <= rs2;
            bus.ID_EX_rd         <= (is_r | is_i | is_l) ? rd : 5'd0;
            bus.ID_EX_funct3     <= funct3;
            bus.ID_EX_funct7b5   <= inst[30];
            bus.ID_EX_reg_write  <= is_r | is_i | is_l;
            bus.ID_EX_mem_read   <= is_l;
            bus.ID_EX_mem_write  <= is_s;
            bus.ID_EX_mem_to_reg <= is_l;
            bus.ID_EX_alu_src    <= is_i | is_l | is_s;
            bus.ID_EX_alu_op     <= bus.pc_src ? 2'b00 : alu_op;
        end
    end
endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed-vector self-checking bench for instruction_decode
module tb_instruction_decode;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    instruction_decode_if bus ();
    instruction_decode dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    localparam logic [31:0] ADD_X8   = {7'd0, 5'd14, 5'd12, 3'b000, 5'd8, 7'b0110011};
    localparam logic [31:0] SW_X14   = {7'd0, 5'd14, 5'd2, 3'b010, 5'd4, 7'b0100011};
    localparam logic [31:0] ADD_X0   = {7'd0, 5'd0, 5'd0, 3'b000, 5'd5, 7'b0110011};
    localparam logic [31:0] LW_X14   = {12'd8, 5'd2, 3'b010, 5'd14, 7'b0000011};
    localparam logic [31:0] LW_X10   = {12'd8, 5'd2, 3'b010, 5'd10, 7'b0000011};
    localparam logic [31:0] ADD_X5   = {7'd0, 5'd14, 5'd19, 3'b000, 5'd5, 7'b0110011};
    localparam logic [31:0] SUB_X10  = {7'b0100000, 5'd8, 5'd12, 3'b000, 5'd10, 7'b0110011};
    localparam logic [31:0] BEQ_12   = {1'b0, 6'd0, 5'd10, 5'd1, 3'b000, 4'b0110, 1'b0, 7'b1100011};
    localparam logic [31:0] BNE_12   = {1'b0, 6'd0, 5'd10, 5'd1, 3'b001, 4'b0110, 1'b0, 7'b1100011};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bus.WB_reg_write = 1'b1;
        bus.WB_rd = r;
        bus.WB_data = d;
        step();
        bus.WB_reg_write = 1'b0;
    endtask

    task automatic set_ex_mem(input logic rw, input logic mr, input logic [4:0] r, input logic [31:0] d);
        bus.EX_MEM_reg_write = rw;
        bus.EX_MEM_mem_read = mr;
        bus.EX_MEM_rd = r;
        bus.EX_MEM_alu_result = d;
    endtask

    initial begin
        reset = 1'b1;
        bus.IF_ID_pc = 32'h0;
        bus.IF_ID_inst = 32'h0;
        set_ex_mem(1'b0, 1'b0, 5'd0, 32'd0);
        bus.WB_reg_write = 1'b0;
        bus.WB_rd = 5'd0;
        bus.WB_data = 32'd0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_reg_write", {31'd0, bus.ID_EX_reg_write}, 32'd0);
        check("rst_rd", {27'd0, bus.ID_EX_rd}, 32'd0);
        check("rst_pc_write", {31'd0, bus.pc_write}, 32'd1);
        check("rst_ifid_write", {31'd0, bus.IF_ID_write}, 32'd1);
        check("rst_pc_src", {31'd0, bus.pc_src}, 32'd0);
        check("rst_flush", {31'd0, bus.IF_flush}, 32'd0);

        wb(5'd12, 32'd5);
        wb(5'd14, 32'd7);
        wb(5'd1, 32'd3);
        wb(5'd10, 32'd3);

        bus.IF_ID_inst = ADD_X8;
        step();
        check("add_rs1_data", bus.ID_EX_rs1_data, 32'd5);
        check("add_rs2_data", bus.ID_EX_rs2_data, 32'd7);
        check("add_rd", {27'd0, bus.ID_EX_rd}, 32'd8);
        check("add_reg_write", {31'd0, bus.ID_EX_reg_write}, 32'd1);
        check("add_alu_op", {30'd0, bus.ID_EX_alu_op}, 32'd2);

        bus.IF_ID_inst = SW_X14;
        wb(5'd14, 32'h1234);
        check("sw_rs2_wt", bus.ID_EX_rs2_data, 32'h1234);
        check("sw_imm", bus.ID_EX_imm, 32'd4);
        check("sw_mem_write", {31'd0, bus.ID_EX_mem_write}, 32'd1);
        check("sw_rd", {27'd0, bus.ID_EX_rd}, 32'd0);

        bus.IF_ID_inst = ADD_X0;
        wb(5'd0, 32'hFFFF);
        check("x0_wt_read", bus.ID_EX_rs1_data, 32'd0);
        step();
        check("x0_read", bus.ID_EX_rs2_data, 32'd0);

        bus.IF_ID_inst = LW_X14;
        step();
        bus.IF_ID_inst = ADD_X5;
        #1;
        check("lu_pc_write", {31'd0, bus.pc_write}, 32'd0);
        check("lu_ifid_write", {31'd0, bus.IF_ID_write}, 32'd0);
        step();
        check("lu_bubble_rw", {31'd0, bus.ID_EX_reg_write}, 32'd0);
        check("lu_bubble_rd", {27'd0, bus.ID_EX_rd}, 32'd0);
        check("lu_release", {31'd0, bus.pc_write}, 32'd1);
        step();
        check("lu_issue_rd", {27'd0, bus.ID_EX_rd}, 32'd5);
        check("lu_issue_data", bus.ID_EX_rs2_data, 32'h1234);

        bus.IF_ID_inst = 32'h0;
        bus.IF_ID_pc = 32'h1C;
        step();
        bus.IF_ID_inst = BEQ_12;
        #1;
        check("beq_pc_src", {31'd0, bus.pc_src}, 32'd1);
        check("beq_target", bus.pc_branch, 32'h28);
        check("beq_flush", {31'd0, bus.IF_flush}, 32'd1);
        step();
        check("beq_idex_rw", {31'd0, bus.ID_EX_reg_write}, 32'd0);
        bus.IF_ID_inst = 32'h0;
        wb(5'd10, 32'd4);
        bus.IF_ID_inst = BEQ_12;
        #1;
        check("beq_nt_pc_src", {31'd0, bus.pc_src}, 32'd0);
        check("beq_nt_flush", {31'd0, bus.IF_flush}, 32'd0);

        bus.IF_ID_inst = SUB_X10;
        step();
        bus.IF_ID_inst = BEQ_12;
        #1;
        check("alu_br_stall", {31'd0, bus.pc_write}, 32'd0);
        check("alu_br_no_take", {31'd0, bus.pc_src}, 32'd0);
        step();
        set_ex_mem(1'b1, 1'b0, 5'd10, 32'd3);
        #1;
        check("alu_br_release", {31'd0, bus.pc_write}, 32'd1);
        check("alu_br_fwd_take", {31'd0, bus.pc_src}, 32'd1);
        step();
        set_ex_mem(1'b0, 1'b0, 5'd0, 32'd0);

        bus.IF_ID_inst = LW_X10;
        step();
        bus.IF_ID_inst = BEQ_12;
        #1;
        check("ld_br_stall1", {31'd0, bus.pc_write}, 32'd0);
        step();
        set_ex_mem(1'b1, 1'b1, 5'd10, 32'hDEAD);
        #1;
        check("ld_br_stall2", {31'd0, bus.pc_write}, 32'd0);
        check("ld_br_no_take", {31'd0, bus.pc_src}, 32'd0);
        step();
        set_ex_mem(1'b0, 1'b0, 5'd0, 32'd0);
        bus.WB_reg_write = 1'b1;
        bus.WB_rd = 5'd10;
        bus.WB_data = 32'd3;
        #1;
        check("ld_br_release", {31'd0, bus.pc_write}, 32'd1);
        check("ld_br_wt_take", {31'd0, bus.pc_src}, 32'd1);
        bus.WB_reg_write = 1'b0;
        bus.IF_ID_inst = 32'h0;
        step();
        wb(5'd10, 32'd4);

        bus.IF_ID_inst = BNE_12;
        #1;
`ifdef ID_BNE_EN
        check("bne_pc_src", {31'd0, bus.pc_src}, 32'd1);
`else
        check("bne_pc_src", {31'd0, bus.pc_src}, 32'd0);
`endif
        step();
        check("bne_alu_op", {30'd0, bus.ID_EX_alu_op}, 32'd0);
        check("bne_reg_write", {31'd0, bus.ID_EX_reg_write}, 32'd0);
        check("bne_mem_write", {31'd0, bus.ID_EX_mem_write}, 32'd0);

        bus.IF_ID_inst = LW_X14;
        step();
        bus.IF_ID_inst = ADD_X5;
        reset = 1'b1;
        wb(5'd12, 32'h55);
        reset = 1'b0;
        bus.IF_ID_inst = {7'd0, 5'd12, 5'd12, 3'b000, 5'd6, 7'b0110011};
        step();
        check("rst_mid_idex_pc", bus.ID_EX_rs1_data, 32'd0);
        check("rst_over_wb", bus.ID_EX_rs2_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the 5-stage RISC-V pipeline, directly downstream of `instruction_fetch`. It consumes the IF/ID register and owns a 32x32 register file, immediate generation, main control decode and the hazard detection unit. Branches are resolved in this stage, and it drives the stall and redirect signals back to fetch. Results are registered into the ID/EX pipeline register.

## Interface
Parameters: none.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `IF_ID_pc` in 32: PC of the instruction in decode.
- `IF_ID_inst` in 32: instruction in decode; `0` means bubble.
- `EX_MEM_reg_write`, `EX_MEM_mem_read` in 1 each: EX/MEM control bits.
- `EX_MEM_rd` in 5: EX/MEM destination register.
- `EX_MEM_alu_result` in 32: EX/MEM ALU result.
- `WB_reg_write` in 1, `WB_rd` in 5, `WB_data` in 32: register-file write port.
- `pc_branch` out 32: branch target; `pc_src` out 1: take branch.
- `pc_write`, `IF_ID_write` out 1 each: fetch enables, both 0 on stall.
- `IF_flush` out 1: squash the instruction currently in fetch.
- `ID_EX_pc`, `ID_EX_rs1_data`, `ID_EX_rs2_data`, `ID_EX_imm` out 32 each.
- `ID_EX_rs1`, `ID_EX_rs2`, `ID_EX_rd` out 5 each.
- `ID_EX_funct3` out 3; `ID_EX_funct7b5` out 1.
- `ID_EX_reg_write`, `ID_EX_mem_read`, `ID_EX_mem_write`, `ID_EX_mem_to_reg`, `ID_EX_alu_src` out 1 each; `ID_EX_alu_op` out 2.

## Operation
- Register file:
  - Write on rising edge when `WB_reg_write` is set and `WB_rd != 0`.
  - `x0` always reads 0.
  - A read of the register being written in the same cycle returns `WB_data` (write-through).
  - Reset clears all 32 entries.
- Decode by opcode (alu_src / alu_op / other controls):
  - R `0110011`: 0 / 10 / reg_write.
  - I-ALU `0010011`: 1 / 11 / reg_write.
  - LW `0000011`: 1 / 00 / reg_write, mem_read, mem_to_reg.
  - SW `0100011`: 1 / 00 / mem_write.
  - BEQ `1100011` funct3 `000`: alu_op 01, no write.
  - Any other opcode: all controls 0, `rd` forced 0.
  - S and B formats: `rd` forced 0.
- Immediates, all sign-extended from `inst[31]`:
  - I: `inst[31:20]`.
  - S: `{inst[31:25], inst[11:7]}`.
  - B: `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`.
  - R: 0.
- Register use: rs1 is used by R/I/L/S/B; rs2 by R/S/B. Register 0 never creates a hazard.
- `stall` is set when any of these holds:
  - (a) `ID_EX_mem_read` and `ID_EX_rd` matches a used rs.
  - (b) The instruction is a branch, `ID_EX_reg_write`, and `ID_EX_rd` matches a used rs.
  - (c) The instruction is a branch, `EX_MEM_mem_read`, and `EX_MEM_rd` matches a used rs.
- On stall:
  - `pc_write=0`, `IF_ID_write=0`.
  - ID/EX loads a bubble: all controls 0, `rd=0`, data fields 0.
  - `pc_src=0`, `IF_flush=0`.
- Branch operands, in priority order:
  1. `EX_MEM_alu_result` if `EX_MEM_reg_write && !EX_MEM_mem_read && EX_MEM_rd != 0` and `EX_MEM_rd` matches.
  2. Otherwise register file with write-through.
- `pc_branch = IF_ID_pc + imm_B`, 32-bit wrap.
- `pc_src = branch && equal && !stall`; `IF_flush = pc_src`.
- A taken branch itself still enters ID/EX, with all controls 0.
- Stall has priority over branch; a branch is never taken in a stall cycle.

## Timing
- ID/EX outputs: registered, 1-cycle latency; all reset to 0.
- `pc_branch`, `pc_src`, `pc_write`, `IF_ID_write`, `IF_flush`: combinational from the current inputs and ID/EX state.
- After reset, with `IF_ID_inst=0`: `pc_write=1`, `IF_ID_write=1`, `pc_src=0`, `IF_flush=0`.
- Stall cost:
  - Load-use: 1 cycle.
  - Branch after an ALU producer: 1 cycle.
  - Branch after a load: 2 cycles.
- Taken-branch penalty: 1 squashed fetch.
- Reset asserted mid-stall: reset wins. ID/EX and the register file clear on that edge, and `reset` overrides a simultaneous WB write.

## Configuration
- `ID_BNE_EN` defined: opcode `1100011` funct3 `001` decodes as a branch with alu_op 01 and `pc_src = branch && !equal && !stall`. It participates in hazard rules (b) and (c) the same as BEQ.
- `ID_BNE_EN` undefined: funct3 `001` under opcode `1100011` decodes as unknown (all controls 0, never taken, no hazard).

## Test plan
- Preload x12=5, x14=7 via WB; decode `add x8,x12,x14` -> next cycle `ID_EX_rs1_data=5`, `ID_EX_rs2_data=7`, `ID_EX_rd=8`, `ID_EX_reg_write=1`, `ID_EX_alu_op=10`.
- WB writes x14=`0x1234` in the same cycle `sw x14,4(x2)` is decoded -> `ID_EX_rs2_data=0x1234`, `ID_EX_imm=4`, `ID_EX_mem_write=1`, `ID_EX_rd=0`. WB write to x0 of `0xFFFF` -> x0 still reads 0.
- `lw x14,8(x2)` then `add x5,x19,x14` -> exactly one cycle with `pc_write=0`, `IF_ID_write=0` and a bubble in ID/EX; add issues on the next cycle.
- x1=x10=3, `IF_ID_pc=0x1C`, `beq x1,x10,12` -> `pc_src=1`, `pc_branch=0x28`, `IF_flush=1`. With x10=4: `pc_src=0`, `IF_flush=0`.
- `sub x10,x12,x8` immediately before `beq x1,x10,12` -> 1 stall cycle, then the compare uses `EX_MEM_alu_result`. Producer is `lw` -> 2 stall cycles.
- With `ID_BNE_EN`: `bne` on x1=3, x10=4 -> `pc_src=1`. Without it -> `pc_src=0` and all ID/EX controls 0.
